// File: rtl/booth_div_pkg.sv
// Shared types and constants for the signed sequential divider.
// The state enum is also used by the bench to decode the debug state output.
package booth_div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 5;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 16'hFFFF;
    localparam logic [DIV_WIDTH-1:0] MIN_NEG      = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_D,
        CHECK,
        ITER,
        CORRECT,
        DONE
    } div_state_t;

endpackage

// File: rtl/booth_div_datapath.sv
// Operand capture plus the non-restoring shift/add/subtract engine.
// Every register is written only under a control strobe from the FSM.
module booth_div_datapath
    import booth_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_dividend,
    input  logic             load_divisor,
    input  logic             init,
    input  logic             step,
    input  logic             correct,
    input  logic             dbz_result,
    output logic             divisor_zero,
    output logic             min_neg_by_m1,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   acc_shift;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH:0]   acc_fix;

    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
        m_ext        = {1'b0, m};
        // Add/subtract choice uses the sign of A before the shift; the shifted
        // value always fits in WIDTH+1 bits because |A| < M going in.
        acc_shift    = {acc[WIDTH-1:0], q[WIDTH-1]};
        acc_next     = acc[WIDTH] ? (acc_shift + m_ext) : (acc_shift - m_ext);
        acc_fix      = acc[WIDTH] ? (acc + m_ext) : acc;
    end

    assign divisor_zero  = (divisor == '0);
    assign min_neg_by_m1 = (dividend == MIN_NEG) && (divisor == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            dividend  <= '0;
            divisor   <= '0;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (load_dividend) begin
                dividend <= data_in;
            end
            if (load_divisor) begin
                divisor <= data_in;
            end
            if (init) begin
                acc   <= '0;
                q     <= dividend_mag;
                m     <= divisor_mag;
                q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_neg <= dividend[WIDTH-1];
            end
            if (step) begin
                acc <= acc_next;
                q   <= {q[WIDTH-2:0], ~acc_next[WIDTH]};
            end
            if (correct) begin
                acc       <= acc_fix;
                quotient  <= q_neg ? -q : q;
                remainder <= r_neg ? -acc_fix[WIDTH-1:0] : acc_fix[WIDTH-1:0];
            end
            if (dbz_result) begin
                quotient  <= DBZ_QUOTIENT;
                remainder <= dividend;
            end
        end
    end

endmodule

// File: rtl/booth_divider_top.sv
// Signed sequential divider: control FSM and iteration counter around the datapath.
// Shares the operand bus and start/ldd/done protocol with the Booth multiplier.
module booth_divider_top
    import booth_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ldd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             ovf,
    output div_state_t       dbg_state
);

    // Handshake: start is accepted only in IDLE or DONE, with the dividend on
    // data_in that cycle; the divisor must be on data_in during the single ldd
    // cycle; done is sticky and results stay stable until the next completion.

    div_state_t           state;
    logic [DIV_CNT_W-1:0] cnt;

    logic accept;
    logic load_divisor;
    logic init;
    logic step;
    logic correct;
    logic dbz_result;
    logic divisor_zero;
    logic min_neg_by_m1;

    always_comb begin
        accept       = ((state == IDLE) || (state == DONE)) && start;
        load_divisor = (state == LOAD_D);
        init         = (state == CHECK) && !divisor_zero;
        dbz_result   = (state == CHECK) && divisor_zero;
        step         = (state == ITER);
        correct      = (state == CORRECT);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ldd   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD_D;
                        ldd   <= 1'b1;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        dbz   <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                LOAD_D: begin
                    ldd   <= 1'b0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (divisor_zero) begin
                        dbz   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt   <= DIV_CNT_W'(WIDTH);
                        state <= ITER;
                    end
                end
                ITER: begin
                    cnt <= cnt - DIV_CNT_W'(1);
                    if (cnt == DIV_CNT_W'(1)) begin
                        state <= CORRECT;
                    end
                end
                CORRECT: begin
                    ovf   <= min_neg_by_m1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    booth_div_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .load_dividend(accept),
        .load_divisor (load_divisor),
        .init         (init),
        .step         (step),
        .correct      (correct),
        .dbz_result   (dbz_result),
        .divisor_zero (divisor_zero),
        .min_neg_by_m1(min_neg_by_m1),
        .quotient     (quotient),
        .remainder    (remainder)
    );

endmodule

// File: tb/tb_booth_divider_top.sv
// Bench for booth_divider_top: directed cases from the operation rules plus random
// operands, scored against an integer-arithmetic reference model.
module tb_booth_divider_top;
    import booth_div_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        ldd;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dbz;
    logic        ovf;
    div_state_t  dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected {dbz, ovf, quotient, remainder}
    logic [33:0] exp_q[$];

    booth_divider_top #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .ldd      (ldd),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dbz      (dbz),
        .ovf      (ovf),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain signed integer division (truncating), remainder
    // follows dividend; divide-by-zero and the single overflow case special-cased.
    function automatic logic [33:0] model(input logic [15:0] dvd, input logic [15:0] dvs);
        int a;
        int b;
        int qi;
        int ri;
        logic [15:0] q16;
        logic [15:0] r16;
        a = int'($signed(dvd));
        b = int'($signed(dvs));
        if (b == 0) return {1'b1, 1'b0, 16'hFFFF, dvd};
        if (a == -32768 && b == -1) return {1'b0, 1'b1, 16'h8000, 16'h0000};
        qi  = a / b;
        ri  = a % b;
        q16 = qi[15:0];
        r16 = ri[15:0];
        return {2'b00, q16, r16};
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge right after done is seen.
    task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs, input int pulse_at);
        logic [33:0] exp;
        int lat;
        int ldd_extra;
        bit seen;
        exp_q.push_back(model(dvd, dvs));
        start   = 1'b1;
        data_in = dvd;
        @(posedge clk);
        @(negedge clk);
        check("ldd_load", ldd, 1);
        check("busy_load", busy, 1);
        check("done_clear", done, 0);
        start   = 1'b0;
        data_in = dvs;
        @(posedge clk);
        @(negedge clk);
        data_in   = 16'($urandom);
        lat       = 0;
        ldd_extra = 0;
        seen      = 1'b0;
        for (int k = 2; k <= 40 && !seen; k++) begin
            if (ldd) ldd_extra++;
            start = (k == pulse_at);
            if (k == pulse_at) data_in = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            lat   = k;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 1);
        check("ldd_outside_load", ldd_extra, 0);
        exp = exp_q.pop_front();
        check("latency", lat, exp[33] ? 2 : 19);
        check("quotient", quotient, exp[31:16]);
        check("remainder", remainder, exp[15:0]);
        check("dbz", dbz, exp[33]);
        check("ovf", ovf, exp[32]);
        check("busy_done", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, dbg_state, IDLE);
        check({tag, "_outs"}, {ldd, busy, done, dbz, ovf}, 0);
        check({tag, "_q"}, quotient, 0);
        check({tag, "_r"}, remainder, 0);
    endtask

    // Start an op, hit reset so it is sampled at edge E10, and check the flush.
    task automatic reset_mid(input logic [15:0] dvd, input logic [15:0] dvs);
        start   = 1'b1;
        data_in = dvd;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        data_in = dvs;
        @(posedge clk);
        @(negedge clk);
        for (int k = 2; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] a;
        logic [15:0] b;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op(16'hFFCE, 16'd10, 0);          // -50 / 10
        run_op(16'd50, 16'hFFF6, 0);          // 50 / -10
        run_op(16'd7, 16'hFFFE, 0);           // 7 / -2, then back-to-back
        run_op(16'hFFF9, 16'd2, 0);           // -7 / 2
        run_op(16'd1234, 16'd0, 0);           // divide by zero
        run_op(16'h8000, 16'hFFFF, 0);        // overflow case
        run_op(16'h8000, 16'd1, 0);
        run_op(16'd1000, 16'd3, 8);           // start pulse during ITER ignored
        run_op(16'hFC18, 16'hFFFD, 12);

        reset_mid(16'd500, 16'd9);
        @(negedge clk);
        run_op(16'd100, 16'd7, 0);

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            case ($urandom_range(0, 5))
                0:       b = 16'd0;
                1:       b = 16'hFFFF;
                2:       b = 16'($urandom_range(1, 20));
                3:       b = -16'($urandom_range(1, 20));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            run_op(a, b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
